// File: rtl/fp_video_pkg.sv
// Shared definitions for the FrontPanel BlockPipeIn to AXI4-Stream video packer.
// Holds the control state encoding, status word bit positions, pixel width and
// the pixels-per-clock legality check used at elaboration.
package fp_video_pkg;

   localparam int unsigned PIXEL_W = 24;

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StDone,
      StErr
   } state_e;

   localparam int unsigned StatBatchDone = 0;
   localparam int unsigned StatOverflow  = 1;
   localparam int unsigned StatCfgError  = 2;
   localparam int unsigned StatRunning   = 3;
   localparam int unsigned StatFramesLsb = 16;

   function automatic bit ppc_legal(input int unsigned ppc);
      return (ppc == 1) || (ppc == 2) || (ppc == 4);
   endfunction

endpackage

// File: rtl/fp_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with synchronous flush.
// Ports:
//   clk_i, rst_i      clock, asynchronous active-high reset
//   flush_i           empties the FIFO; overrides a same-cycle write or read
//   wr_en_i/wr_data_i write request; ignored while full
//   rd_en_i           pop the head word; ignored while empty
//   rd_data_o         head word, valid whenever !empty_o
//   empty_o, full_o   occupancy flags
//   free_o            number of free word slots
module fp_sync_fifo #(
   parameter int unsigned Depth = 8192,
   parameter int unsigned Width = 32
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         flush_i,
   input  logic                         wr_en_i,
   input  logic [Width-1:0]             wr_data_i,
   input  logic                         rd_en_i,
   output logic [Width-1:0]             rd_data_o,
   output logic                         empty_o,
   output logic                         full_o,
   output logic [$clog2(Depth+1)-1:0]   free_o
);

   localparam int unsigned AddrW = $clog2(Depth);
   localparam int unsigned CntW  = $clog2(Depth + 1);

   logic [Width-1:0] mem_q [Depth];
   logic [AddrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]  count_q, count_d;
   logic             wr_ok, rd_ok;

   assign empty_o   = (count_q == '0);
   assign full_o    = (count_q == CntW'(Depth));
   assign free_o    = CntW'(Depth) - count_q;
   assign rd_data_o = mem_q[rd_ptr_q];

   assign wr_ok = wr_en_i && !full_o && !flush_i;
   assign rd_ok = rd_en_i && !empty_o && !flush_i;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         // Depth is a power of two, so pointers wrap naturally.
         if (wr_ok) wr_ptr_d = wr_ptr_q + AddrW'(1);
         if (rd_ok) rd_ptr_d = rd_ptr_q + AddrW'(1);
         count_d = count_q + CntW'(wr_ok) - CntW'(rd_ok);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (wr_ok) mem_q[wr_ptr_q] <= wr_data_i;
   end

endmodule

// File: rtl/fp_btpipe_video_packer.sv
// FrontPanel BlockPipeIn to AXI4-Stream Video bridge.
// Host 32-bit words are buffered in a FIFO, then a read-side gearbox repacks the
// packed 24-bit pixel stream into PPC-pixel beats. SOF (tuser) and EOL (tlast)
// come from line/frame/batch counters latched at start.
// Ports:
//   aclk, areset                  clock, asynchronous active-high reset
//   cfg_*                         geometry and colour config, latched on start
//   start                         restart: flush, clear counters/status, latch cfg
//   status                        [0] batch_done [1] overflow [2] cfg_error
//                                 [3] running [31:16] frames completed
//   btpi_ep_*                     FrontPanel BlockPipeIn endpoint
//   m_axis_*                      AXI4-Stream video master
module fp_btpipe_video_packer
   import fp_video_pkg::*;
#(
   parameter int unsigned PPC         = 2,
   parameter int unsigned FIFO_DEPTH  = 8192,
   parameter int unsigned BLOCK_WORDS = 4096
) (
   input  logic                     aclk,
   input  logic                     areset,
   input  logic [15:0]              cfg_beats_per_line,
   input  logic [15:0]              cfg_lines_per_frame,
   input  logic [31:0]              cfg_frames_in_batch,
   input  logic                     cfg_color_swap,
   input  logic                     start,
   output logic [31:0]              status,
   input  logic [31:0]              btpi_ep_dataout,
   input  logic                     btpi_ep_write,
   input  logic                     btpi_ep_blockstrobe,
   output logic                     btpi_ep_ready,
   output logic [PIXEL_W*PPC-1:0]   m_axis_tdata,
   output logic [3*PPC-1:0]         m_axis_tkeep,
   output logic                     m_axis_tvalid,
   input  logic                     m_axis_tready,
   output logic                     m_axis_tuser,
   output logic                     m_axis_tlast
);

   localparam int unsigned PW    = PIXEL_W * PPC;
   localparam int unsigned AccW  = PW + 32;
   localparam int unsigned FillW = $clog2(AccW + 1);
   localparam int unsigned CntW  = $clog2(FIFO_DEPTH + 1);

   if (!ppc_legal(PPC)) begin : g_ppc_check
      $error("PPC must be 1, 2 or 4");
   end

   state_e            state_q, state_d;
   logic [15:0]       bpl_q, lpf_q;
   logic [31:0]       fib_q;
   logic              swap_q;
   logic [15:0]       beat_q, beat_d, line_q, line_d;
   logic [31:0]       frame_q, frame_d;
   logic              done_q, done_d, ovf_q, ovf_d;
   logic [AccW-1:0]   acc_q, acc_d, acc_shift;
   logic [FillW-1:0]  fill_q, fill_d, fill_rem;

   logic [31:0]       fifo_rdata;
   logic              fifo_empty, fifo_full, fifo_pop;
   logic [CntW-1:0]   fifo_free;
   logic              beat_hs;
   logic              unused_blockstrobe;

   assign unused_blockstrobe = btpi_ep_blockstrobe;

   fp_sync_fifo #(
      .Depth (FIFO_DEPTH),
      .Width (32)
   ) u_fifo (
      .clk_i     (aclk),
      .rst_i     (areset),
      .flush_i   (start),
      .wr_en_i   (btpi_ep_write),
      .wr_data_i (btpi_ep_dataout),
      .rd_en_i   (fifo_pop),
      .rd_data_o (fifo_rdata),
      .empty_o   (fifo_empty),
      .full_o    (fifo_full),
      .free_o    (fifo_free)
   );

   assign btpi_ep_ready = (fifo_free >= CntW'(BLOCK_WORDS));

   // tvalid depends only on registered state, so start/reset drop it the next cycle.
   assign m_axis_tvalid = (state_q == StRun) && (fill_q >= FillW'(PW));
   assign m_axis_tuser  = m_axis_tvalid && (beat_q == '0) && (line_q == '0);
   assign m_axis_tlast  = m_axis_tvalid && (beat_q == bpl_q - 16'd1);
   assign m_axis_tkeep  = '1;
   assign beat_hs       = m_axis_tvalid && m_axis_tready;

   always_comb begin
      m_axis_tdata = acc_q[PW-1:0];
      if (swap_q) begin
         // Host {B,G,R} (R in the low byte) becomes {R,B,G}.
         for (int p = 0; p < int'(PPC); p++) begin
            m_axis_tdata[p*PIXEL_W +: PIXEL_W] = {acc_q[p*PIXEL_W +: 8],
                                                  acc_q[p*PIXEL_W+16 +: 8],
                                                  acc_q[p*PIXEL_W+8 +: 8]};
         end
      end
   end

   // Gearbox: the emitted beat leaves from the bottom, new words land above the
   // remaining bits. The low PW bits never change while a beat is stalled.
   always_comb begin
      fill_rem  = fill_q - (beat_hs ? FillW'(PW) : FillW'(0));
      acc_shift = beat_hs ? (acc_q >> PW) : acc_q;
      fifo_pop  = !start && !fifo_empty && (fill_rem <= FillW'(PW));
      acc_d     = acc_shift;
      fill_d    = fill_rem;
      if (start) begin
         acc_d  = '0;
         fill_d = '0;
      end else if (fifo_pop) begin
         acc_d  = acc_shift | (AccW'(fifo_rdata) << fill_rem);
         fill_d = fill_rem + FillW'(32);
      end
   end

   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      line_d  = line_q;
      frame_d = frame_q;
      done_d  = done_q;
      ovf_d   = ovf_q | (btpi_ep_write && fifo_full);
      if (start) begin
         beat_d  = '0;
         line_d  = '0;
         frame_d = '0;
         done_d  = 1'b0;
         ovf_d   = 1'b0;
         state_d = (cfg_beats_per_line == '0 || cfg_lines_per_frame == '0) ? StErr : StRun;
      end else if (beat_hs) begin
         if (beat_q == bpl_q - 16'd1) begin
            beat_d = '0;
            if (line_q == lpf_q - 16'd1) begin
               line_d = '0;
               if (frame_q != '1) frame_d = frame_q + 32'd1;
               if (fib_q != '0 && frame_q + 32'd1 == fib_q) begin
                  done_d  = 1'b1;
                  state_d = StDone;
               end
            end else begin
               line_d = line_q + 16'd1;
            end
         end else begin
            beat_d = beat_q + 16'd1;
         end
      end
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state_q <= StIdle;
         bpl_q   <= '0;
         lpf_q   <= '0;
         fib_q   <= '0;
         swap_q  <= 1'b0;
         beat_q  <= '0;
         line_q  <= '0;
         frame_q <= '0;
         done_q  <= 1'b0;
         ovf_q   <= 1'b0;
         acc_q   <= '0;
         fill_q  <= '0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         line_q  <= line_d;
         frame_q <= frame_d;
         done_q  <= done_d;
         ovf_q   <= ovf_d;
         acc_q   <= acc_d;
         fill_q  <= fill_d;
         if (start) begin
            bpl_q  <= cfg_beats_per_line;
            lpf_q  <= cfg_lines_per_frame;
            fib_q  <= cfg_frames_in_batch;
            swap_q <= cfg_color_swap;
         end
      end
   end

   always_comb begin
      status                = '0;
      status[StatBatchDone] = done_q;
      status[StatOverflow]  = ovf_q;
      status[StatCfgError]  = (state_q == StErr);
      status[StatRunning]   = (state_q == StRun);
      status[StatFramesLsb +: 16] = frame_q[15:0];
   end

endmodule

// File: doc/fp_btpipe_video_packer.md
# fp_btpipe_video_packer

Parametrised FrontPanel BlockPipeIn to AXI4-Stream Video bridge, next generation of the fixed 2-pixel RGB converter in the DisplayPort path. It buffers 32-bit host words in an internal FIFO, repacks packed 24-bit pixels into PPC-pixel beats with a read-side gearbox so downstream backpressure is honoured, and generates SOF (tuser) and EOL (tlast) from a latched line/frame/batch configuration. It sits between the FrontPanel endpoints and the video processing subsystem.

## Interface
- PPC, 2, pixels per beat; legal 1, 2, 4
- FIFO_DEPTH, 8192, input FIFO depth in 32-bit words; power of 2, ≥ 2×BLOCK_WORDS
- BLOCK_WORDS, 4096, host block size in 32-bit words (16 KB)

- aclk  in  1  sole clock
- areset  in  1  asynchronous, active-high reset
- cfg_beats_per_line  in  16  beats per line
- cfg_lines_per_frame  in  16  lines per frame
- cfg_frames_in_batch  in  32  frames per batch; 0 = continuous
- cfg_color_swap  in  1  1 = host R,G,B byte order to AMD G,B,R; 0 = raw
- start  in  1  single-cycle trigger (TriggerIn bit)
- status  out  32  [0] batch_done, [1] overflow, [2] cfg_error, [3] running, [31:16] frames completed (low 16 bits)
- btpi_ep_dataout  in  32  host data
- btpi_ep_write  in  1  host write strobe
- btpi_ep_blockstrobe  in  1  block start (informational, unused for control)
- btpi_ep_ready  out  1  space for a full block
- m_axis_tdata  out  24×PPC  pixels, pixel 0 in LSBs
- m_axis_tkeep  out  3×PPC  all ones
- m_axis_tvalid / m_axis_tready  out / in  1  AXI4-Stream handshake
- m_axis_tuser  out  1  SOF, first beat of each frame
- m_axis_tlast  out  1  EOL, last beat of each line

## Operation
- States: IDLE (after reset), RUN, DONE, ERR. start in any state: flush FIFO and accumulator, clear counters and status bits 0-2, latch cfg_*; go to ERR if beats_per_line or lines_per_frame is 0, else RUN.
- Input: btpi_ep_write pushes the word in every state. btpi_ep_ready = free words ≥ BLOCK_WORDS. A write while full drops the word and sets sticky overflow.
- Gearbox: accumulator of 24×PPC+32 bits with a fill counter in bits. Output valid when fill ≥ 24×PPC and state is RUN. Pop one FIFO word per cycle when FIFO is non-empty and (fill − emitted bits) ≤ 24×PPC. New words are appended above existing bits. One beat per cycle maximum.
- Colour: cfg_color_swap=1 maps each host pixel {B,G,R} (R in the LSB byte) to {R,B,G}. cfg_color_swap=0 passes the bits unchanged.
- Counters advance on tvalid&&tready only: beat in line, line in frame, frame in batch. tuser = (beat==0 && line==0); tlast = (beat==beats_per_line−1).
- After the last beat of frame cfg_frames_in_batch: set batch_done and go to DONE. In DONE tvalid is low and the FIFO keeps accepting words. With frames_in_batch = 0, DONE is never reached.
- ERR: tvalid is low and cfg_error=1 until the next start.
- running = (state==RUN).

## Timing
- Reset values: tvalid, tuser, tlast, status, fill and all counters 0; btpi_ep_ready 1; state IDLE.
- Latency from the first host write (edge t) to first tvalid, when RUN and the FIFO is empty: PPC=1 t+2, PPC=2 t+3, PPC=4 t+4.
- tdata, tuser and tlast are stable while tvalid && !tready. The only exceptions are start and reset, which drop tvalid immediately.
- start on the same cycle as a write: the flush wins and the word is discarded.
- start on the same cycle as a handshake: the handshake completes and the counters clear.
- Count widths: 16/16/32 bits with no wrap. The frame counter saturates at 2^32−1.
- Sustained throughput: PPC=1 one beat per cycle; PPC=4 one beat per 3 cycles (bounded by the input word rate).

## Structure
- Package fp_video_pkg holds the state enum, status bit indices, the PPC legality check, and the PIXEL_W=24 constant.
- Sub-module fp_sync_fifo: 32-bit first-word-fall-through FIFO with flush, full/empty, and free-count outputs.

## Test plan
- PPC=2, swap=1, line=4, lines=2, batch=1; 12 words with bytes 0x00..0x2F, tready=1 → 8 beats; beat0 = {0x03,0x05,0x04,0x00,0x02,0x01}, tuser on beat 0, tlast on beats 3 and 7, then batch_done=1 and state DONE.
- PPC=4, random tready at 30% → identical beat sequence to tready=1; tdata stable during stalls; frame counter = 1.
- Write 8192 words with tready=0 → ready falls once free < 4096; write 8193 sets overflow=1; data already in the FIFO is intact.
- cfg_beats_per_line=0 with start → cfg_error=1, tvalid stays low while words are pushed; a valid start → RUN, cfg_error=0.
- start mid-beat with tvalid=1, tready=0 → next cycle tvalid=0, FIFO empty, counters 0, next beat carries tuser.
- PPC=1, batch=0, 1000 frames of 2×2 → never DONE; status[31:16] = 1000.
